// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: memory-control bit positions,
// the default-width entry layout and the occupancy state encoding.
package pipe_pkg;

    // mem field is {read, write}
    localparam int MEM_RD = 1;
    localparam int MEM_WR = 0;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int MEM_CW_DEF = 2;

    // Default-width entry; the stage rebuilds the same layout from its own parameters.
    typedef struct packed {
        logic                  wb;
        logic [MEM_CW_DEF-1:0] mem;
        logic [XLEN_DEF-1:0]   alu_res;
        logic [XLEN_DEF-1:0]   rs2;
        logic [REG_AW_DEF-1:0] rd;
    } ex_mem_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/ex_mem_pipe_stage_if.sv
// EX-side and MEM-side signals of the EX->MEM stage.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never waits for ready, and a presented entry stays stable until it transfers or is flushed.
interface ex_mem_pipe_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int MEM_CW = 2,
    parameter int CNT_W  = 16
) ();
    logic              in_valid_i;
    logic              in_ready_o;
    logic              wb_i;
    logic [MEM_CW-1:0] mem_i;
    logic [XLEN-1:0]   alu_res_i;
    logic [XLEN-1:0]   rs2_data_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              wb_o;
    logic [MEM_CW-1:0] mem_o;
    logic [XLEN-1:0]   alu_res_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_data_o;
    logic [REG_AW-1:0] rd_addr_o;
    logic              fwd_valid_o;
    logic [XLEN-1:0]   fwd_data_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output in_valid_i, wb_i, mem_i, alu_res_i, rs2_data_i, rd_addr_i, out_ready_i,
        input  in_ready_o, out_valid_o, wb_o, mem_o, alu_res_o, mem_addr_o, mem_data_o,
               rd_addr_o, fwd_valid_o, fwd_data_o, stall_cnt_o
    );

    modport slave (
        input  in_valid_i, wb_i, mem_i, alu_res_i, rs2_data_i, rd_addr_i, out_ready_i,
        output in_ready_o, out_valid_o, wb_o, mem_o, alu_res_o, mem_addr_o, mem_data_o,
               rd_addr_o, fwd_valid_o, fwd_data_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry register with synchronous clear and load enable.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_o <= '0;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: valid/ready handshake, flush, optional 2-entry skid buffer,
// forwarding tap and a saturating stall counter. state_o exposes the occupancy FSM.
module ex_mem_pipe_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int MEM_CW = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    output pipe_state_e state_o,
    ex_mem_pipe_stage_if.slave bus
);

    typedef struct packed {
        logic              wb;
        logic [MEM_CW-1:0] mem;
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   rs2;
        logic [REG_AW-1:0] rd;
    } ent_t;

    localparam int EW = $bits(ent_t);

    pipe_state_e      state_q, state_n;
    ent_t             in_ent, main_q, main_d, skid_q;
    logic             main_load, main_from_skid;
    logic             out_valid, in_ready, accept, consume;
    logic [CNT_W-1:0] stall_q;

    assign in_ent    = {bus.wb_i, bus.mem_i, bus.alu_res_i, bus.rs2_data_i, bus.rd_addr_i};
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid_i & in_ready;
    assign consume   = out_valid & bus.out_ready_i;
    assign main_d    = main_from_skid ? skid_q : in_ent;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_n;
        end
    end

    // Flush wins over both accept and consume; held data is left in place, only validity drops.
    always_comb begin
        state_n        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_n = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_n   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_n = ST_FULL;
                    end else if (consume) begin
                        state_n = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        state_n        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_n = ST_EMPTY;
            endcase
        end
    end

    pipe_slot #(.W(EW)) u_main (
        .clk_i  (clk_i),
        .clr_i  (rst_i),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;
            logic skid_load;

            assign skid_load = (state_q == ST_ONE) & accept & ~consume & ~flush_i;

            // Ready looks only at the next state, so it never depends on an input combinationally.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_n != ST_FULL);
                end
            end

            assign in_ready = rdy_q;

            pipe_slot #(.W(EW)) u_skid (
                .clk_i  (clk_i),
                .clr_i  (rst_i),
                .load_i (skid_load),
                .d_i    (in_ent),
                .q_o    (skid_q)
            );
        end else begin : g_noskid
            assign in_ready = ~out_valid | bus.out_ready_i;
            assign skid_q   = '0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (out_valid && !bus.out_ready_i && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign state_o         = state_q;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.wb_o        = main_q.wb & out_valid;
    assign bus.mem_o       = out_valid ? main_q.mem : '0;
    assign bus.alu_res_o   = main_q.alu_res;
    assign bus.mem_addr_o  = main_q.alu_res;
    assign bus.mem_data_o  = main_q.rs2;
    assign bus.rd_addr_o   = main_q.rd;
    assign bus.fwd_valid_o = out_valid & main_q.wb & (main_q.rd != '0);
    assign bus.fwd_data_o  = main_q.alu_res;
    assign bus.stall_cnt_o = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage: a SKID=1 instance (b/dut) and a SKID=0 instance (b0/dut0).
module tb_ex_mem_pipe_stage;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    pipe_state_e st, st0;
    int          checks;
    int          errors;

    ex_mem_pipe_stage_if #(.XLEN(32), .REG_AW(5), .MEM_CW(2), .CNT_W(16)) b ();
    ex_mem_pipe_stage_if #(.XLEN(32), .REG_AW(5), .MEM_CW(2), .CNT_W(16)) b0 ();

    ex_mem_pipe_stage #(.XLEN(32), .REG_AW(5), .MEM_CW(2), .SKID(1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .state_o(st), .bus(b)
    );

    ex_mem_pipe_stage #(.XLEN(32), .REG_AW(5), .MEM_CW(2), .SKID(0), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .state_o(st0), .bus(b0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change after the falling edge; outputs are checked there too
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic wb, input logic [1:0] mem,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
        b.in_valid_i = v;
        b.wb_i       = wb;
        b.mem_i      = mem;
        b.alu_res_i  = alu;
        b.rs2_data_i = rs2;
        b.rd_addr_i  = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7);
        b.out_ready_i = 1'b1;
        tick();
        tick();
        checks++; if (b.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", b.out_valid_o); end
        checks++; if (b.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", b.in_ready_o); end
        checks++; if (b.alu_res_o !== 32'h0) begin errors++; $display("FAIL reset_alu_res: got %h exp 0", b.alu_res_o); end
        checks++; if (b.stall_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h exp 0", b.stall_cnt_o); end
        checks++; if (st !== ST_EMPTY) begin errors++; $display("FAIL reset_state: got %0d exp 0", st); end
        checks++; if (b0.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready_noskid: got %b exp 1", b0.in_ready_o); end
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        rst = 1'b0;
        tick();
        checks++; if (b.out_valid_o !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b exp 0", b.out_valid_o); end
    endtask

    task automatic test_single();
        b.out_ready_i = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 32'h10, 32'hAA, 5'd5);
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        checks++; if (b.out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", b.out_valid_o); end
        checks++; if (b.mem_addr_o !== 32'h10) begin errors++; $display("FAIL single_addr: got %h exp 10", b.mem_addr_o); end
        checks++; if (b.mem_data_o !== 32'hAA) begin errors++; $display("FAIL single_data: got %h exp aa", b.mem_data_o); end
        checks++; if (b.rd_addr_o !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d exp 5", b.rd_addr_o); end
        checks++; if (b.fwd_valid_o !== 1'b1) begin errors++; $display("FAIL single_fwd_valid: got %b exp 1", b.fwd_valid_o); end
        checks++; if (b.fwd_data_o !== 32'h10) begin errors++; $display("FAIL single_fwd_data: got %h exp 10", b.fwd_data_o); end
        tick();
        checks++; if (b.out_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %b exp 0", b.out_valid_o); end
        checks++; if (b.wb_o !== 1'b0) begin errors++; $display("FAIL single_wb_bubble: got %b exp 0", b.wb_o); end
    endtask

    task automatic test_back_to_back();
        b.out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 32'hA1, 32'hA2, 5'd1);
        tick();
        drive(1'b1, 1'b1, 2'b01, 32'hB1, 32'hB2, 5'd2);
        tick();
        checks++; if (st !== ST_FULL) begin errors++; $display("FAIL b2b_full_state: got %0d exp 2", st); end
        checks++; if (b.in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b exp 0", b.in_ready_o); end
        drive(1'b1, 1'b1, 2'b11, 32'hC1, 32'hC2, 5'd3);
        tick();
        checks++; if (b.alu_res_o !== 32'hA1 || b.mem_data_o !== 32'hA2 || b.mem_o !== 2'b10)
            begin errors++; $display("FAIL b2b_hold_a: got %h/%h/%b exp a1/a2/10", b.alu_res_o, b.mem_data_o, b.mem_o); end
        checks++; if (b.in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_c_blocked: got %b exp 0", b.in_ready_o); end
        b.out_ready_i = 1'b1;
        tick();
        checks++; if (b.alu_res_o !== 32'hB1 || b.rd_addr_o !== 5'd2) begin errors++; $display("FAIL b2b_second_b: got %h/%0d exp b1/2", b.alu_res_o, b.rd_addr_o); end
        checks++; if (b.in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b exp 1", b.in_ready_o); end
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        checks++; if (b.alu_res_o !== 32'hC1 || b.out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_third_c: got %h/%b exp c1/1", b.alu_res_o, b.out_valid_o); end
        tick();
        checks++; if (b.out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b exp 0", b.out_valid_o); end
    endtask

    task automatic test_flush();
        b.out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 32'h31, 32'h32, 5'd4);
        tick();
        drive(1'b1, 1'b1, 2'b01, 32'h41, 32'h42, 5'd6);
        tick();
        checks++; if (st !== ST_FULL) begin errors++; $display("FAIL flush_pre_full: got %0d exp 2", st); end
        flush = 1'b1;
        drive(1'b1, 1'b1, 2'b11, 32'h51, 32'h52, 5'd8);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        checks++; if (b.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", b.out_valid_o); end
        checks++; if (b.wb_o !== 1'b0 || b.mem_o !== 2'b00) begin errors++; $display("FAIL flush_ctrl: got wb=%b mem=%b exp 0/00", b.wb_o, b.mem_o); end
        checks++; if (b.in_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", b.in_ready_o); end
        checks++; if (b.stall_cnt_o !== 16'd4) begin errors++; $display("FAIL flush_keeps_stall: got %0d exp 4", b.stall_cnt_o); end
        b.out_ready_i = 1'b1;
        tick();
        checks++; if (b.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_entry_lost: got %b exp 0", b.out_valid_o); end
    endtask

    task automatic test_fwd_bubble();
        b.out_ready_i = 1'b1;
        drive(1'b1, 1'b1, 2'(1 << MEM_WR), 32'h55, 32'h66, 5'd0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        checks++; if (b.wb_o !== 1'b1 || b.mem_o !== 2'b01) begin errors++; $display("FAIL fwd_rd0_ctrl: got wb=%b mem=%b exp 1/01", b.wb_o, b.mem_o); end
        checks++; if (b.fwd_valid_o !== 1'b0) begin errors++; $display("FAIL fwd_rd0: got %b exp 0", b.fwd_valid_o); end
        tick();
        checks++; if (b.mem_o !== 2'b00 || b.wb_o !== 1'b0) begin errors++; $display("FAIL bubble_ctrl: got wb=%b mem=%b exp 0/00", b.wb_o, b.mem_o); end
        checks++; if (b.alu_res_o !== 32'h55) begin errors++; $display("FAIL bubble_data_kept: got %h exp 55", b.alu_res_o); end
    endtask

    task automatic test_stall_sat();
        b.out_ready_i = 1'b0;
        drive(1'b1, 1'b1, 2'b10, 32'h71, 32'h72, 5'd9);
        tick();
        drive(1'b1, 1'b1, 2'b01, 32'h81, 32'h82, 5'd10);
        tick();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < (1 << 16) + 3; i++) tick();
        checks++; if (b.stall_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h exp ffff", b.stall_cnt_o); end
        checks++; if (st !== ST_FULL || b.alu_res_o !== 32'h71) begin errors++; $display("FAIL stall_hold: got st=%0d alu=%h exp 2/71", st, b.alu_res_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (b.stall_cnt_o !== 16'h0) begin errors++; $display("FAIL stall_reset: got %h exp 0", b.stall_cnt_o); end
        checks++; if (b.in_ready_o !== 1'b1 || b.out_valid_o !== 1'b0) begin errors++; $display("FAIL full_reset_hs: got rdy=%b vld=%b exp 1/0", b.in_ready_o, b.out_valid_o); end
        checks++; if (b.alu_res_o !== 32'h0 || b.mem_data_o !== 32'h0) begin errors++; $display("FAIL full_reset_data: got %h/%h exp 0/0", b.alu_res_o, b.mem_data_o); end
        b.out_ready_i = 1'b1;
        tick();
        checks++; if (b.out_valid_o !== 1'b0) begin errors++; $display("FAIL full_reset_skid_gone: got %b exp 0", b.out_valid_o); end
    endtask

    task automatic test_noskid();
        b0.out_ready_i = 1'b0;
        b0.in_valid_i  = 1'b1;
        b0.wb_i        = 1'b1;
        b0.mem_i       = 2'(1 << MEM_RD);
        b0.alu_res_i   = 32'h91;
        b0.rs2_data_i  = 32'h92;
        b0.rd_addr_i   = 5'd11;
        tick();
        checks++; if (b0.out_valid_o !== 1'b1 || b0.alu_res_o !== 32'h91) begin errors++; $display("FAIL noskid_first: got %b/%h exp 1/91", b0.out_valid_o, b0.alu_res_o); end
        checks++; if (b0.in_ready_o !== 1'b0) begin errors++; $display("FAIL noskid_ready_low: got %b exp 0", b0.in_ready_o); end
        b0.alu_res_i = 32'hA5;
        b0.rd_addr_i = 5'd12;
        tick();
        checks++; if (b0.alu_res_o !== 32'h91 || st0 !== ST_ONE) begin errors++; $display("FAIL noskid_hold: got %h/%0d exp 91/1", b0.alu_res_o, st0); end
        b0.out_ready_i = 1'b1;
        #1;
        checks++; if (b0.in_ready_o !== 1'b1) begin errors++; $display("FAIL noskid_ready_comb: got %b exp 1", b0.in_ready_o); end
        tick();
        b0.in_valid_i = 1'b0;
        checks++; if (b0.alu_res_o !== 32'hA5 || b0.rd_addr_o !== 5'd12 || b0.out_valid_o !== 1'b1)
            begin errors++; $display("FAIL noskid_pass: got %h/%0d/%b exp a5/12/1", b0.alu_res_o, b0.rd_addr_o, b0.out_valid_o); end
        tick();
        checks++; if (b0.out_valid_o !== 1'b0) begin errors++; $display("FAIL noskid_drain: got %b exp 0", b0.out_valid_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        flush  = 1'b0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
        b.out_ready_i  = 1'b1;
        b0.in_valid_i  = 1'b0;
        b0.wb_i        = 1'b0;
        b0.mem_i       = 2'b00;
        b0.alu_res_i   = 32'h0;
        b0.rs2_data_i  = 32'h0;
        b0.rd_addr_i   = 5'd0;
        b0.out_ready_i = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_fwd_bubble();
        test_noskid();
        test_stall_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
